// File: rtl/fs_accel_iwin_loader.sv
// fs_accel_iwin_loader: gathers 9 row-major pixel bytes into three 3-wide rows for a row demux.
// Define FS_ACCEL_ILOAD_ABORT_EN to add the iload_abort input.
module fs_accel_iwin_loader #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          iload_start,
    input  logic          iload_in_valid,
    input  logic [DW-1:0] iload_in_data,
`ifdef FS_ACCEL_ILOAD_ABORT_EN
    input  logic          iload_abort,
`endif
    output logic          iload_in_ready,
    output logic [DW-1:0] iload_do_0,
    output logic [DW-1:0] iload_do_1,
    output logic [DW-1:0] iload_do_2,
    output logic [1:0]    iload_sel,
    output logic          iload_wr,
    output logic          iload_busy,
    output logic          iload_done
);
    typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] col, row;
    logic [DW-1:0] slot_0, slot_1;
    logic abort, acc;
`ifdef FS_ACCEL_ILOAD_ABORT_EN
    assign abort = iload_abort && (state != IDLE);
`else
    assign abort = 1'b0;
`endif
    // an aborted cycle captures nothing, so the output row never changes without a wr
    assign acc = (state == FILL) && iload_in_valid && !abort;
    assign iload_in_ready = (state == FILL);
    assign iload_wr = (state == EMIT);
    assign iload_busy = (state != IDLE);
    assign iload_done = (state == DONE);
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = iload_start ? FILL : IDLE;
            FILL: state_nx = (acc && col == 2'd2) ? EMIT : FILL;
            EMIT: state_nx = (row == 2'd2) ? DONE : FILL;
            DONE: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
            slot_0 <= '0;
            slot_1 <= '0;
            iload_do_0 <= '0;
            iload_do_1 <= '0;
            iload_do_2 <= '0;
            iload_sel <= '0;
        end else begin
            if (abort || (state == IDLE && iload_start)) begin
                col <= '0;
                row <= '0;
            end else begin
                if (acc) col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
                if (state == EMIT && row != 2'd2) row <= row + 2'd1;
            end
            if (acc && col == 2'd0) slot_0 <= iload_in_data;
            if (acc && col == 2'd1) slot_1 <= iload_in_data;
            // the third byte goes straight to the output row alongside the two held ones
            if (acc && col == 2'd2) begin
                iload_do_0 <= slot_0;
                iload_do_1 <= slot_1;
                iload_do_2 <= iload_in_data;
                iload_sel <= row;
            end
        end
    end
endmodule

// File: tb/tb_fs_accel_iwin_loader.sv
// tb_fs_accel_iwin_loader: scoreboard bench for the 3x3 window loader.
// Define FS_ACCEL_ILOAD_ABORT_EN to also exercise iload_abort.
module tb_fs_accel_iwin_loader;
    localparam int DW = 8;
    logic clk = 0, resetn = 0, iload_start = 0, iload_in_valid = 0;
    logic [DW-1:0] iload_in_data = '0;
    logic iload_in_ready, iload_wr, iload_busy, iload_done;
    logic [DW-1:0] iload_do_0, iload_do_1, iload_do_2;
    logic [1:0] iload_sel;
`ifdef FS_ACCEL_ILOAD_ABORT_EN
    logic iload_abort = 0;
`endif
    fs_accel_iwin_loader #(.DW(DW)) dut (
        .clk(clk), .resetn(resetn), .iload_start(iload_start),
        .iload_in_valid(iload_in_valid), .iload_in_data(iload_in_data),
`ifdef FS_ACCEL_ILOAD_ABORT_EN
        .iload_abort(iload_abort),
`endif
        .iload_in_ready(iload_in_ready), .iload_do_0(iload_do_0), .iload_do_1(iload_do_1),
        .iload_do_2(iload_do_2), .iload_sel(iload_sel), .iload_wr(iload_wr),
        .iload_busy(iload_busy), .iload_done(iload_done)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;
    typedef struct {
        logic [1:0] sel;
        logic [DW-1:0] d0, d1, d2;
    } row_t;
    row_t rowq[$];
    int doneq[$];
    int total = 0, bad = 0;
    row_t mr;
    int me;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    // monitor: pops expectations whenever the DUT presents a row or a done pulse
    always @(negedge clk) begin
        if (resetn) begin
            chk("ready_in_fill", 32'(iload_in_ready), 32'(iload_busy && !iload_wr && !iload_done));
            if (iload_wr) begin
                chk("wr_expected", 32'(rowq.size() > 0), 1);
                if (rowq.size() > 0) begin
                    mr = rowq.pop_front();
                    chk("row", {iload_sel, iload_do_0, iload_do_1, iload_do_2}, {mr.sel, mr.d0, mr.d1, mr.d2});
                end
            end
            if (iload_done) begin
                chk("done_expected", 32'(doneq.size() > 0), 1);
                chk("done_after_rows", 32'(rowq.size()), 0);
                if (doneq.size() > 0) begin
                    me = doneq.pop_front();
                    if (me >= 0) chk("done_cycle", 32'(cyc), 32'(me));
                end
            end
        end
    end
    task automatic send(input logic [7:0] v, input int gap);
        int t = 0;
        bit got = 0;
        iload_in_valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
        iload_in_valid = 1;
        iload_in_data = v;
        while (!got && t < 40) begin
            @(negedge clk);
            got = iload_in_ready;
            @(posedge clk); #1;
            t++;
        end
        chk("byte_accepted", 32'(got), 1);
        iload_in_valid = 0;
    endtask
    task automatic push_row(input logic [7:0] b[9], input int r);
        rowq.push_back('{sel: 2'(r), d0: b[3*r], d1: b[3*r+1], d2: b[3*r+2]});
    endtask
    task automatic pulse_start();
        iload_start = 1;
        @(posedge clk); #1;
        iload_start = 0;
    endtask
    // gap < 0 picks a random gap per byte; done timing is only fixed when gap == 0
    task automatic run_window(input logic [7:0] b[9], input int gap, input bit restarts);
        int t = 0;
        for (int r = 0; r < 3; r++) push_row(b, r);
        doneq.push_back(gap == 0 ? cyc + 13 : -1);
        pulse_start();
        fork
            for (int i = 0; i < 9; i++) send(b[i], gap < 0 ? int'($urandom_range(0, 3)) : gap);
            if (restarts) begin
                repeat (2) @(posedge clk);
                #1 iload_start = 1;
                @(posedge clk); #1 iload_start = 0;
                repeat (3) @(posedge clk);
                #1 iload_start = 1;
                @(posedge clk); #1 iload_start = 0;
            end
        join
        while (doneq.size() > 0 && t < 40) begin @(posedge clk); #1; t++; end
        chk("window_done", 32'(doneq.size()), 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_after_window", 32'(iload_busy), 0);
    endtask
    task automatic chk_zero(input string nm);
        chk(nm, {iload_in_ready, iload_wr, iload_busy, iload_done, iload_sel, iload_do_0, iload_do_1, iload_do_2}, 0);
    endtask
    logic [7:0] w[9];
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        repeat (3) @(posedge clk);
        #1 chk_zero("reset_state");
        @(negedge clk) resetn = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) w[i] = 8'(8'h11 * (i + 1));
        run_window(w, 0, 0);
        run_window(w, 2, 0);
        w[3] = 8'hEE;
        run_window(w, 0, 0);
        w[3] = 8'h44;
        run_window(w, 0, 1);
        // reset after byte 5: only row 0 ever reaches the outputs
        push_row(w, 0);
        pulse_start();
        for (int i = 0; i < 5; i++) send(w[i], 0);
        resetn = 0;
        #1 chk_zero("mid_window_reset");
        chk("reset_flushes_rows", 32'(rowq.size()), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) w[i] = 8'(8'hA1 + i);
        run_window(w, 0, 0);
`ifdef FS_ACCEL_ILOAD_ABORT_EN
        push_row(w, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) send(w[i], 0);
        iload_abort = 1;
        @(posedge clk); #1 iload_abort = 0;
        chk("abort_busy", 32'(iload_busy), 0);
        repeat (5) begin @(posedge clk); #1; end
        chk("abort_quiet", 32'(iload_busy), 0);
        for (int i = 0; i < 9; i++) w[i] = 8'(8'hC0 + i);
        run_window(w, 0, 0);
`endif
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 9; i++) w[i] = 8'($urandom);
            run_window(w, k < 2 ? 0 : -1, 0);
        end
        repeat (5) begin @(posedge clk); #1; end
        chk("rows_drained", 32'(rowq.size()), 0);
        chk("dones_drained", 32'(doneq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
